// File: rtl/counter_compare_mc.sv
// Shared prescaled up-counter with CHANNELS compare channels.
// Period/compare values are double-buffered: new values are staged by load and
// become active only at a period boundary (wrap tick in RUN, or while idle/done),
// so a running period is never truncated or restarted by an update.
module counter_compare_mc #(
  parameter int WIDTH      = 20,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      oneshot,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] cmp,
  input  logic                      load,
  output logic [WIDTH-1:0]          count,
  output logic [CHANNELS-1:0]       match,
  output logic                      wrap,
  output logic                      busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                state;
  logic [PRESCALE_W-1:0]     pre;
  logic                      mode_oneshot;
  logic                      pending;
  logic [WIDTH-1:0]          stg_period, act_period;
  logic [CHANNELS*WIDTH-1:0] stg_cmp, act_cmp;

  logic                      run_go;
  logic                      tick;
  logic                      wrap_tick;
  logic                      promote;
  logic [WIDTH-1:0]          last;
  logic [WIDTH-1:0]          next_cnt;
  logic [CHANNELS*WIDTH-1:0] next_cmp;
  logic [CHANNELS-1:0]       match_d;

  assign busy = (state == S_RUN);

  // Tick/wrap decode; start/stop pre-empt counting in the same cycle. A prescaler
  // above a freshly lowered prescale ticks immediately instead of rolling over.
  always_comb begin
    run_go    = (state == S_RUN) && !start && !stop;
    tick      = run_go && (pre >= prescale);
    last      = (act_period == '0) ? '1 : act_period - WIDTH'(1);
    wrap_tick = tick && (count == last);
    next_cnt  = (count == last) ? '0 : count + WIDTH'(1);
  end

  // Compare against the values that are active once count shows next_cnt, so a
  // boundary that swaps in new compares uses them for the count-0 match.
  always_comb begin
    next_cmp = act_cmp;
    if (wrap_tick && load)         next_cmp = cmp;
    else if (wrap_tick && pending) next_cmp = stg_cmp;
    match_d = '0;
    for (int i = 0; i < CHANNELS; i++)
      match_d[i] = tick && (next_cnt == next_cmp[i*WIDTH +: WIDTH]);
  end

  // Control FSM, counter, prescaler and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      count        <= '0;
      pre          <= '0;
      mode_oneshot <= 1'b0;
      match        <= '0;
      wrap         <= 1'b0;
    end else begin
      match <= match_d;
      wrap  <= wrap_tick;
      if (stop) begin
        if (state == S_RUN) state <= S_IDLE;
        pre <= '0;
      end else if (start) begin
        state        <= S_RUN;
        count        <= '0;
        pre          <= '0;
        mode_oneshot <= oneshot;
      end else if (state == S_RUN) begin
        if (tick) begin
          pre   <= '0;
          count <= next_cnt;
          if (wrap_tick && mode_oneshot) state <= S_DONE;
        end else begin
          pre <= pre + PRESCALE_W'(1);
        end
      end
    end
  end

  // Staged/active double buffer for period and compare values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      stg_period <= '0;
      stg_cmp    <= '0;
      act_period <= '0;
      act_cmp    <= '0;
    end else if (load && wrap_tick) begin
      act_period <= period;
      act_cmp    <= cmp;
      pending    <= 1'b0;
    end else begin
      if (pending && promote) begin
        act_period <= stg_period;
        act_cmp    <= stg_cmp;
        pending    <= 1'b0;
      end
      if (load) begin
        stg_period <= period;
        stg_cmp    <= cmp;
        pending    <= 1'b1;
      end
    end
  end

  // Boundaries where staged values may go live: wrap tick, a (re)start, or any
  // cycle outside RUN.
  always_comb promote = wrap_tick || (start && !stop) || (state != S_RUN);

endmodule
